// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Groups the fetch-side, decode-side and branch-redirect signals of the
//   decode-side fetch receiver into a single bundle.
//
//   Fetch side : f_valid, f_pc, f_instr (toward the queue), f_enbl (back-pressure)
//   Decode side: d_valid, d_pc, d_instr (toward decode), d_ready (accept)
//   Branch     : flush, flush_pc (taken branch), redir, redir_pc (redirect pulse)
//   Status     : level (occupancy, 0..DEPTH)
//
//   slave  : the queue's view (drives f_enbl, d_*, redir*, level)
//   master : the surrounding pipeline's view
//   DEPTH must match the DEPTH of the fetch_queue attached to this interface.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          f_valid;
  logic [6:0]    f_pc;
  logic [31:0]   f_instr;
  logic          f_enbl;

  logic          d_valid;
  logic          d_ready;
  logic [6:0]    d_pc;
  logic [31:0]   d_instr;

  logic          flush;
  logic [6:0]    flush_pc;
  logic          redir;
  logic [6:0]    redir_pc;

  logic [AW:0]   level;

  modport slave (
    input  f_valid, f_pc, f_instr, d_ready, flush, flush_pc,
    output f_enbl, d_valid, d_pc, d_instr, redir, redir_pc, level
  );

  modport master (
    output f_valid, f_pc, f_instr, d_ready, flush, flush_pc,
    input  f_enbl, d_valid, d_pc, d_instr, redir, redir_pc, level
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Decode-side receiver for the fetch stage. Captures each fetched
//   (PC, instruction) pair into a DEPTH-entry FIFO and presents the head to
//   decode with a valid/ready handshake. Fetch is throttled through f_enbl.
//   A taken branch (flush) empties the queue, drops the one wrong-path fetch
//   arriving in the following cycle (SQUASH), and raises a one-cycle redirect.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-low reset
//     bus  - fetch_queue_if.slave (f_*, d_*, flush*, redir*, level)
//
//   DEPTH is a power of two in 2..8.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [38:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, wr_ptr_next;
  logic [AW-1:0]   rd_ptr, rd_ptr_next;
  logic [AW:0]     count,  count_next;
  logic [38:0]     head;
  logic            enbl;
  logic            not_empty;
  logic            push;
  logic            pop;

  // Enable depends on registered state only, so fetch never sees a
  // combinational path from any input.
  assign enbl      = (state == RUN) && (count != FULL_COUNT);
  assign not_empty = (count != '0);
  assign push      = bus.f_valid && enbl;
  assign pop       = not_empty && bus.d_ready;

  // State, pointer and occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state  <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Next-state logic. A flush wins over any push or pop in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next  = RUN;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;

    if (bus.flush) begin
      state_next  = SQUASH;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // In SQUASH, enbl is low (drops the wrong-path fetch) and the queue is
      // empty, so neither push nor pop can fire there.
      if (push) wr_ptr_next = wr_ptr + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count_next = count + (AW+1)'(1);
        2'b01:   count_next = count - (AW+1)'(1);
        default: count_next = count;
      endcase
    end
  end

  // Storage array.
  // NOTE: the array carries no reset; occupancy and pointers alone decide
  // which entries are meaningful, and outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem[wr_ptr] <= {bus.f_pc, bus.f_instr};
    end
  end

  // Redirect pulse: high only in the cycle after a flush; the target is kept
  // until the next flush reloads it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.redir    <= 1'b0;
      bus.redir_pc <= '0;
    end else begin
      bus.redir <= bus.flush;
      if (bus.flush) bus.redir_pc <= bus.flush_pc;
    end
  end

  assign head        = mem[rd_ptr];
  assign bus.f_enbl  = enbl;
  assign bus.d_valid = not_empty;
  assign bus.d_pc    = not_empty ? head[38:32] : '0;
  assign bus.d_instr = not_empty ? head[31:0]  : '0;
  assign bus.level   = count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Randomized and directed stimulus for fetch_queue. A driver applies one
//   cycle of inputs at a time, checks the status outputs against a
//   transaction-level model (occupancy counter, squash flag, redirect
//   registers) and records each accepted fetch in a scoreboard queue.
//   A separate monitor compares whatever decode sees against the scoreboard
//   head and retires entries on each accepted handshake.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [6:0]  pc;
    logic [31:0] instr;
  } entry_t;

  entry_t     sb[$];
  int         n_checks = 0;
  int         n_errors = 0;

  int         m_count;
  bit         m_squash;
  bit         m_redir;
  logic [6:0] m_redir_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_count    = 0;
    m_squash   = 1'b0;
    m_redir    = 1'b0;
    m_redir_pc = '0;
    sb.delete();
  endfunction

  function automatic bit model_enbl();
    return !m_squash && (m_count != DEPTH);
  endfunction

  task automatic drive_idle();
    bus.f_valid  = 1'b0;
    bus.f_pc     = '0;
    bus.f_instr  = '0;
    bus.d_ready  = 1'b0;
    bus.flush    = 1'b0;
    bus.flush_pc = '0;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit fv, input logic [6:0] pc, input logic [31:0] instr,
                      input bit dr, input bit fl, input logic [6:0] fpc);
    bit en;
    bit push;
    bit pop;
    en = model_enbl();
    bus.f_valid  = fv;
    bus.f_pc     = pc;
    bus.f_instr  = instr;
    bus.d_ready  = dr;
    bus.flush    = fl;
    bus.flush_pc = fpc;
    @(negedge clk);
    check("f_enbl",   bus.f_enbl,   en);
    check("level",    bus.level,    m_count);
    check("redir",    bus.redir,    m_redir);
    check("redir_pc", bus.redir_pc, m_redir_pc);
    @(posedge clk);
    #1;
    if (fl) begin
      m_count    = 0;
      m_squash   = 1'b1;
      m_redir    = 1'b1;
      m_redir_pc = fpc;
      sb.delete();
    end else begin
      push = fv && en;
      pop  = dr && (m_count != 0);
      if (push) sb.push_back('{pc: pc, instr: instr});
      m_count    = m_count + int'(push) - int'(pop);
      m_squash   = 1'b0;
      m_redir    = 1'b0;
    end
  endtask

  task automatic idle(input bit dr);
    step(1'b0, '0, '0, dr, 1'b0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (m_count != 0) idle(1'b1);
    end
  endtask

  // Monitor: compares the decode-side view with the scoreboard and retires
  // an entry whenever the coming edge accepts the head.
  initial begin
    forever begin
      @(negedge clk);
      check("d_valid", bus.d_valid, sb.size() != 0);
      if (bus.d_valid && sb.size() != 0) begin
        check("d_pc",    bus.d_pc,    sb[0].pc);
        check("d_instr", bus.d_instr, sb[0].instr);
        if (bus.d_ready && !bus.flush && rst) void'(sb.pop_front());
      end else if (!bus.d_valid) begin
        check("d_pc_empty",    bus.d_pc,    7'h00);
        check("d_instr_empty", bus.d_instr, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    drive_idle();
    rst = 1'b0;
    #2;
    check("rst_level",   bus.level,   0);
    check("rst_d_valid", bus.d_valid, 0);
    check("rst_f_enbl",  bus.f_enbl,  1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single push, visible one cycle later.
    step(1'b1, 7'd1, 32'hA5A5_0001, 1'b0, 1'b0, '0);
    idle(1'b0);
    drain();

    // Fill to full with decode stalled, then offer a fifth fetch.
    for (int i = 1; i <= 4; i++) step(1'b1, 7'(i), 32'hF000_0000 + i, 1'b0, 1'b0, '0);
    step(1'b1, 7'd5, 32'hF000_0005, 1'b0, 1'b0, '0);
    step(1'b1, 7'd5, 32'hF000_0005, 1'b1, 1'b0, '0);
    idle(1'b0);
    drain();

    // Streaming: one push and one pop every cycle.
    for (int i = 0; i <= 20; i++) step(1'b1, 7'(i), 32'h5000_0000 + i, 1'b1, 1'b0, '0);
    drain();

    // Flush with three queued entries plus a simultaneous push and pop.
    for (int i = 1; i <= 3; i++) step(1'b1, 7'(i), 32'hC000_0000 + i, 1'b0, 1'b0, '0);
    step(1'b1, 7'd8, 32'hC000_0008, 1'b1, 1'b1, 7'h40);
    step(1'b1, 7'd9, 32'hC000_0009, 1'b1, 1'b0, '0);
    idle(1'b1);
    idle(1'b1);

    // Random traffic with occasional flushes; exercises pointer wrap.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 7'($urandom), $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0, 7'($urandom));
    end
    drain();

    // Back-to-back flushes, then asynchronous reset while in SQUASH.
    step(1'b1, 7'd3, 32'hB000_0003, 1'b0, 1'b0, '0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 7'h10);
    step(1'b1, 7'd4, 32'hB000_0004, 1'b0, 1'b1, 7'h20);
    check("b2b_redir",    bus.redir,    1);
    check("b2b_redir_pc", bus.redir_pc, 7'h20);
    #2;
    rst = 1'b0;
    #1;
    check("async_redir",    bus.redir,    0);
    check("async_redir_pc", bus.redir_pc, 7'h00);
    check("async_f_enbl",   bus.f_enbl,   1);
    check("async_level",    bus.level,    0);
    check("async_d_valid",  bus.d_valid,  0);
    model_reset();
    drive_idle();
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 7'd6, 32'hD000_0006, 1'b0, 1'b0, '0);
    idle(1'b1);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decode-side receiver for the fetch stage: captures each fetched (PC, instruction) pair into a small FIFO and presents it to the decode stage through a valid/ready handshake. It back-pressures fetch through the fetch enable, and on a taken branch it flushes all queued entries, squashes the one in-flight wrong-path fetch, and issues a one-cycle redirect pulse. It sits between the fetch stage outputs (PC, DR) and the decode stage inputs.

## Interface

Parameters:
- DEPTH, 4, number of queue entries; a power of two, 2..8. AW = log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- f_valid  in  1  fetch stage presents a valid instruction this cycle
- f_pc  in  7  PC of the presented instruction
- f_instr  in  32  presented instruction word (fetch DR)
- f_enbl  out  1  enable to the fetch stage; a push occurs only when f_valid && f_enbl
- d_valid  out  1  head entry valid toward decode
- d_ready  in  1  decode accepts the head; a pop occurs when d_valid && d_ready
- d_pc  out  7  head PC
- d_instr  out  32  head instruction
- flush  in  1  taken branch: discard the queue and redirect
- flush_pc  in  7  branch target
- redir  out  1  one-cycle redirect pulse to fetch
- redir_pc  out  7  redirect target, valid while redir=1
- level  out  AW+1  current occupancy, 0..DEPTH

## Operation

- Storage: DEPTH x 39-bit array {pc, instr}, with wr_ptr and rd_ptr (AW bits, wrap modulo DEPTH) and count (AW+1 bits). The array is not reset.
- States:
  - RUN: normal operation.
  - SQUASH: exactly one cycle after a flush.
- f_enbl = (state==RUN) && (count != DEPTH). It is combinational from registered state only and has no path from inputs.
- RUN, no flush:
  - Push writes mem[wr_ptr] and increments wr_ptr.
  - Pop increments rd_ptr.
  - count += push - pop. A push and a pop in the same cycle leave count unchanged.
- Full: f_enbl=0, so no push occurs even when a pop happens in the same cycle. There is no bypass.
- Empty: d_valid=0, and d_pc and d_instr are forced to 0. There is no bypass from f_* to d_*.
- d_valid = (count != 0). d_pc and d_instr = mem[rd_ptr] when not empty.
- flush=1, in any state:
  - count, wr_ptr and rd_ptr clear to 0.
  - Any push or pop in that cycle is ignored.
  - Next state is SQUASH.
  - redir is 1 and redir_pc is flush_pc on the next cycle.
- SQUASH:
  - f_valid is ignored; the wrong-path instruction is dropped.
  - f_enbl=0 and d_valid=0 (the queue is empty).
  - Next state is RUN, unless flush=1, which re-enters SQUASH and reloads redir_pc with the new flush_pc.
- redir: registered. It is 1 only in the cycle after a flush, otherwise 0. redir_pc holds its last value while redir=0.
- level = count.
- Reset (rst=0, asynchronous, overrides flush):
  - state RUN, count, pointers 0.
  - redir 0, redir_pc 0, level 0, d_valid 0, d_pc 0, d_instr 0.
  - f_enbl evaluates to 1.

## Timing

- Push to visibility: an entry pushed at edge N is on d_* with d_valid=1 after edge N (latency 1 cycle).
- Pop: d_* advance to the next entry after the accepting edge.
- Throughput: one push and one pop per cycle, sustained while 0 < count < DEPTH.
- Flush at edge N:
  - After N: d_valid=0, level=0, redir=1, redir_pc=flush_pc, state SQUASH, f_enbl=0.
  - After N+1: redir=0, state RUN, f_enbl=1.
- Reset asserted mid-operation: outputs take their reset values immediately (asynchronous). Release is sampled at the next rising edge.

## Test plan

- Reset then single push: rst=0 gives level=0, d_valid=0, f_enbl=1. After release, push pc=1, instr=32'hA5A5_0001. The next cycle shows d_valid=1, d_pc=1, d_instr=32'hA5A5_0001, level=1.
- Fill to full with d_ready=0: push pc=1..4. Then level=4 and f_enbl=0; a fifth f_valid with pc=5 is not stored. Pop once: the next head is pc=2 and f_enbl returns to 1.
- Streaming: f_valid=1 and d_ready=1 continuously with pc=0..20. Decode receives pc 0..20 in order with no gaps after the first cycle, and level stays at 1.
- Wrap-around: more than 2*DEPTH pushes and pops with random d_ready. Output order and data match a reference queue, and pointers wrap without loss.
- Flush with the queue holding 3 entries, flush_pc=7'h40, plus a simultaneous push and pop:
  - Next cycle: level=0, redir=1, redir_pc=7'h40, f_enbl=0.
  - Presented f_valid with pc=9 is dropped in SQUASH.
  - The following cycle: redir=0, f_enbl=1.
- Back-to-back flushes (flush_pc=7'h10, then 7'h20) and asynchronous reset mid-SQUASH:
  - redir stays 1 for two cycles, with redir_pc 7'h10 then 7'h20.
  - rst=0 clears redir and the state immediately.
